hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core. It detects load-use hazards, EX-stage control-flow redirects and data-memory wait states. It drives the bubble select into the ID/EX control mux (ctrl_select = 0 zeroes ID/EX control) and the write/flush enables of the PC and the pipeline registers. It contains a small FSM for multi-cycle stalls and flushes, plus a memory-wait watchdog.

---
 rtl/hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, redirect flushes, memory-wait freeze and watchdog.
// Optional performance counters are enabled with `define HAZARD_PERF_EN.
module hazard_ctrl #(
    parameter int unsigned LU_STALL_CYC = 1,
    parameter int unsigned FLUSH_EXTRA  = 0,
    parameter int unsigned MEM_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        ex_redirect,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        ctrl_select,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_write,
    output logic        ex_mem_write,
    output logic        mem_wb_bubble,
    output logic        mem_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush,
    output logic [31:0] perf_wait
`endif
);

    localparam int unsigned CNT_W  = 2;
    localparam int unsigned WAIT_W = 16;
    localparam logic [CNT_W-1:0]  LU_CNT_INIT = (LU_STALL_CYC > 1) ? CNT_W'(LU_STALL_CYC - 2) : '0;
    localparam logic [CNT_W-1:0]  FL_CNT_INIT = (FLUSH_EXTRA > 0) ? CNT_W'(FLUSH_EXTRA - 1) : '0;
    localparam logic [WAIT_W-1:0] TIMEOUT     = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {RUN, LU_STALL, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              freeze;
    logic              lu;

    assign freeze = mem_req & ~mem_ready;
    assign lu     = ex_memread & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            wait_q  <= '0;
            mem_err <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            if (wait_d == TIMEOUT)
                mem_err <= 1'b1;
        end
    end

    // Watchdog counter: saturating count of consecutive freeze cycles
    always_comb begin
        wait_d = '0;
        if (freeze)
            wait_d = (wait_q == TIMEOUT) ? wait_q : wait_q + WAIT_W'(1);
    end

    // Next state and hazard controls; freeze overrides, reset overrides all
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ctrl_select   = 1'b1;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        mem_wb_bubble = 1'b0;

        if (freeze) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    // Redirect wins: the instruction in ID is wrong-path
                    if (ex_redirect) begin
                        if_id_flush = 1'b1;
                        ctrl_select = 1'b0;
                        if (FLUSH_EXTRA > 0) begin
                            state_d = FLUSH;
                            cnt_d   = FL_CNT_INIT;
                        end
                    end else if (lu) begin
                        ctrl_select = 1'b0;
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        if (LU_STALL_CYC > 1) begin
                            state_d = LU_STALL;
                            cnt_d   = LU_CNT_INIT;
                        end
                    end
                end
                LU_STALL: begin
                    ctrl_select = 1'b0;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    if (cnt_q == '0) state_d = RUN;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                FLUSH: begin
                    if_id_flush = 1'b1;
                    ctrl_select = 1'b0;
                    if (cnt_q == '0) state_d = RUN;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end

        if (rst) begin
            ctrl_select   = 1'b0;
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_write   = 1'b1;
            ex_mem_write  = 1'b1;
            mem_wb_bubble = 1'b0;
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating event counters; load-use bubbles are the only non-reset case with pc held and ctrl zeroed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall <= '0;
            perf_flush <= '0;
            perf_wait  <= '0;
        end else begin
            if (~ctrl_select & ~pc_write & (perf_stall != '1))
                perf_stall <= perf_stall + 32'd1;
            if (if_id_flush & (perf_flush != '1))
                perf_flush <= perf_flush + 32'd1;
            if (freeze & (perf_wait != '1))
                perf_wait <= perf_wait + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default instance and one with LU_STALL_CYC=3, FLUSH_EXTRA=2, MEM_TIMEOUT=8.
module tb_hazard_ctrl;

    // {ctrl_select, pc_write, if_id_write, if_id_flush, id_ex_write, ex_mem_write, mem_wb_bubble}
    localparam logic [6:0] O_DEF = 7'b1110110;
    localparam logic [6:0] O_BUB = 7'b0000110;
    localparam logic [6:0] O_FLS = 7'b0111110;
    localparam logic [6:0] O_FRZ = 7'b1000001;
    localparam logic [6:0] O_RST = 7'b0001110;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_memread, ex_redirect, mem_req, mem_ready;

    logic a_cs, a_pc, a_ifw, a_iff, a_idx, a_exm, a_wbb, a_err;
    logic b_cs, b_pc, b_ifw, b_iff, b_idx, b_exm, b_wbb, b_err;
    logic [6:0] out_a, out_b;

`ifdef HAZARD_PERF_EN
    logic [31:0] a_ps, a_pf, a_pw, b_ps, b_pf, b_pw;
`endif

    int checks = 0;
    int errors = 0;

    assign out_a = {a_cs, a_pc, a_ifw, a_iff, a_idx, a_exm, a_wbb};
    assign out_b = {b_cs, b_pc, b_ifw, b_iff, b_idx, b_exm, b_wbb};

    always #5 clk = ~clk;

    hazard_ctrl u_dut_a (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
        .ctrl_select(a_cs), .pc_write(a_pc), .if_id_write(a_ifw), .if_id_flush(a_iff),
        .id_ex_write(a_idx), .ex_mem_write(a_exm), .mem_wb_bubble(a_wbb), .mem_err(a_err)
`ifdef HAZARD_PERF_EN
        , .perf_stall(a_ps), .perf_flush(a_pf), .perf_wait(a_pw)
`endif
    );

    hazard_ctrl #(.LU_STALL_CYC(3), .FLUSH_EXTRA(2), .MEM_TIMEOUT(8)) u_dut_b (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
        .ctrl_select(b_cs), .pc_write(b_pc), .if_id_write(b_ifw), .if_id_flush(b_iff),
        .id_ex_write(b_idx), .ex_mem_write(b_exm), .mem_wb_bubble(b_wbb), .mem_err(b_err)
`ifdef HAZARD_PERF_EN
        , .perf_stall(b_ps), .perf_flush(b_pf), .perf_wait(b_pw)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs are then changed 1 unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_memread = 0; ex_redirect = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        ex_memread = 1; ex_rd = rd; id_rs1 = rd; id_use_rs1 = 1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        #3;
        check("rst_out_a", 32'(out_a), 32'(O_RST));
        check("rst_out_b", 32'(out_b), 32'(O_RST));
        check("rst_err_b", 32'(b_err), 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        check("idle_a", 32'(out_a), 32'(O_DEF));
        check("idle_b", 32'(out_b), 32'(O_DEF));

        // Load-use: one bubble on default, three on b even after EX holds the bubble
        cyc();
        set_lu(5'd5); #1;
        check("lu_a_c0", 32'(out_a), 32'(O_BUB));
        check("lu_b_c0", 32'(out_b), 32'(O_BUB));
        cyc();
        ex_memread = 0; #1;
        check("lu_a_c1", 32'(out_a), 32'(O_DEF));
        check("lu_b_c1", 32'(out_b), 32'(O_BUB));
        cyc(); #1;
        check("lu_b_c2", 32'(out_b), 32'(O_BUB));
        cyc(); #1;
        check("lu_b_c3", 32'(out_b), 32'(O_DEF));
        check("lu_a_c3", 32'(out_a), 32'(O_DEF));

        // x0 destination never stalls; rs2 path does
        clear_inputs();
        set_lu(5'd0); #1;
        check("lu_x0_a", 32'(out_a), 32'(O_DEF));
        check("lu_x0_b", 32'(out_b), 32'(O_DEF));
        clear_inputs();
        ex_memread = 1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1; id_rs1 = 5'd7; #1;
        check("lu_rs2_a", 32'(out_a), 32'(O_BUB));
        id_use_rs2 = 0; #1;
        check("lu_nouse_a", 32'(out_a), 32'(O_DEF));
        do_reset();

        // Redirect beats load-use; b flushes for 3 cycles
        set_lu(5'd3); ex_redirect = 1; #1;
        check("rd_a_c0", 32'(out_a), 32'(O_FLS));
        check("rd_b_c0", 32'(out_b), 32'(O_FLS));
        cyc();
        clear_inputs(); #1;
        check("rd_a_c1", 32'(out_a), 32'(O_DEF));
        check("rd_b_c1", 32'(out_b), 32'(O_FLS));
        cyc();
        ex_redirect = 1; #1;
        check("rd_b_c2_ign", 32'(out_b), 32'(O_FLS));
        cyc();
        ex_redirect = 0; #1;
        check("rd_b_c3", 32'(out_b), 32'(O_DEF));
        do_reset();

        // Freeze with pending redirect: 4 frozen cycles, flush on the 5th
        mem_req = 1; mem_ready = 0; ex_redirect = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("frz_a_%0d", i), 32'(out_a), 32'(O_FRZ));
            check($sformatf("frz_b_%0d", i), 32'(out_b), 32'(O_FRZ));
            cyc();
        end
        mem_ready = 1; #1;
        check("frz_rd_a", 32'(out_a), 32'(O_FLS));
        check("frz_rd_b", 32'(out_b), 32'(O_FLS));
        check("frz_err_b", 32'(b_err), 32'd0);
        cyc();
        clear_inputs(); #1;
        check("frz_post_a", 32'(out_a), 32'(O_DEF));
        check("frz_post_b", 32'(out_b), 32'(O_FLS));
        do_reset();

        // Watchdog: b errors once 8 freeze cycles have elapsed
        mem_req = 1; mem_ready = 0;
        for (int k = 1; k <= 10; k++) begin
            #1;
            check($sformatf("wd_b_%0d", k), 32'(b_err), (k >= 9) ? 32'd1 : 32'd0);
            check($sformatf("wd_a_%0d", k), 32'(a_err), 32'd0);
            cyc();
        end
        mem_ready = 1; #1;
        check("wd_sticky0", 32'(b_err), 32'd1);
        cyc();
        mem_req = 0; #1;
        check("wd_sticky1", 32'(b_err), 32'd1);
        check("wd_out_b", 32'(out_b), 32'(O_DEF));
        #2;
        rst = 1'b1; #1;
        check("wd_rst_clr", 32'(b_err), 32'd0);
        cyc();
        rst = 1'b0;

        // Async reset in FLUSH with cnt=1 aborts immediately
        ex_redirect = 1; #1;
        check("ar_b_c0", 32'(out_b), 32'(O_FLS));
        cyc();
        ex_redirect = 0; #1;
        check("ar_b_c1", 32'(out_b), 32'(O_FLS));
        #1;
        rst = 1'b1; #1;
        check("ar_b_rst", 32'(out_b), 32'(O_RST));
        check("ar_a_rst", 32'(out_a), 32'(O_RST));
        cyc();
        rst = 1'b0; #1;
        check("ar_b_run", 32'(out_b), 32'(O_DEF));
        cyc(); #1;
        check("ar_b_run2", 32'(out_b), 32'(O_DEF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
